instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 The module SHALL have parameter DEPTH, default 64, maximum number of words written per load session (range 1..1024).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 in_valid  input  1  instruction fields valid.
REQ-007 in_ready  output  1  encoder can accept fields.
REQ-008 in_last  input  1  the current field set is the final instruction of the session.
REQ-009 Cond  input  4  condition field.
REQ-010 Op  input  2  00 = data-processing, 01 = memory, 10 = branch, 11 = illegal.
REQ-011 Funct  input  6  instruction bits [25:20].
REQ-012 Rn, Rd  input  4 each  register fields.
REQ-013 Src2  input  12  operand-2 / offset field.
REQ-014 Imm24  input  24  branch offset (used only when Op = 10).
REQ-015 MemWE  output  1  instruction-memory write strobe.
REQ-016 Adr  output  32  instruction-memory byte address.
REQ-017 WD  output  32  encoded instruction word.
REQ-018 count  output  11  number of words written in the current session.
REQ-019 done  output  1  session complete.
REQ-020 err  output  1  sticky illegal-instruction flag.

Function
REQ-021 Encoding SHALL be as follows. For Op 00 or 01: WD = {Cond, Op, Funct, Rn, Rd, Src2}. For Op 10: WD = {Cond, 2'b10, Funct[5:4], Imm24}.
REQ-022 The FSM SHALL have four states: IDLE, LOAD, WRITE and DONE.
REQ-023 IDLE: in_ready = 0. On start, count clears and the FSM goes to LOAD.
REQ-024 LOAD: in_ready = 1. A handshake (in_valid & in_ready) captures all field inputs into registers.
REQ-025 On a legal handshake, LOAD SHALL go to WRITE.
REQ-026 WRITE SHALL last exactly one cycle. During it: MemWE = 1, Adr = BASE_ADDR + 4*count, WD = encoded captured word. count increments at the end of the cycle.
REQ-027 Write latency: fields accepted at edge N SHALL produce MemWE high during the cycle following edge N.
REQ-028 Throughput SHALL be one word per two cycles. in_ready = 0 in WRITE.
REQ-029 After WRITE, the FSM SHALL go to DONE if the captured in_last was 1 or count reaches DEPTH; otherwise it returns to LOAD.
REQ-030 An illegal handshake (Op = 11) SHALL set err, produce no write, and leave count unchanged.
REQ-031 After an illegal handshake, the FSM SHALL go to DONE if in_last = 1, else stay in LOAD.
REQ-032 DONE: done = 1 and in_ready = 0. start SHALL clear count, done and err, and go to LOAD.
REQ-033 start SHALL be ignored in LOAD and WRITE.
REQ-034 Outside WRITE: MemWE = 0, and Adr/WD SHALL hold their last values.
REQ-035 in_valid while in_ready = 0 SHALL be ignored (no capture, no error).

Reset
REQ-036 On reset low, the FSM SHALL asynchronously enter IDLE. All outputs SHALL go to 0: in_ready, MemWE, Adr, WD, count, done, err.
REQ-037 Reset asserted during WRITE SHALL drop MemWE immediately, and the partial session SHALL be discarded.

Configuration
REQ-038 With macro ENCODER_CMD_CHECK_EN defined, an Op = 00 handshake with Funct[4:1] not in {0100, 0010, 0000, 1100} SHALL be treated as illegal: err set, no write.
REQ-039 Without ENCODER_CMD_CHECK_EN, all Op = 00 words SHALL be encoded as given; only Op = 11 is illegal.

Verification
REQ-040 Scenario: start; Cond=E, Op=00, Funct=101000, Rn=2, Rd=1, Src2=005. Required: MemWE one cycle later, Adr=BASE_ADDR, WD=E2821005.
REQ-041 Scenario: Cond=E, Op=10, Funct=100000, Imm24=000003, in_last=1. Required: WD=EA000003, then done=1, count=1.
REQ-042 Scenario: Cond=E, Op=01, Funct=011000, Rn=0, Rd=3, Src2=008. Required: WD=E5803008.
REQ-043 Scenario: DEPTH=4, 6 back-to-back valid words. Required: exactly 4 writes at BASE_ADDR+0/4/8/C, then done=1, count=4, remaining words not accepted.
REQ-044 Scenario: Op=11 word between two legal words. Required: err=1, 2 writes at consecutive addresses; a following start clears err.
REQ-045 Scenario: reset low mid-WRITE. Required: MemWE=0 in the same cycle, FSM in IDLE, count=0; with ENCODER_CMD_CHECK_EN, Funct=100110 sets err with no write.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Handshake and instruction-memory write bus for instr_encoder.
// master drives the field set; slave is the encoder.
interface instr_encoder_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rn;
  logic [3:0]  Rd;
  logic [11:0] Src2;
  logic [23:0] Imm24;
  logic        MemWE;
  logic [31:0] Adr;
  logic [31:0] WD;
  logic [10:0] count;
  logic        done;
  logic        err;

  modport master (
    output start, in_valid, in_last, Cond, Op, Funct, Rn, Rd, Src2, Imm24,
    input  in_ready, MemWE, Adr, WD, count, done, err
  );

  modport slave (
    input  start, in_valid, in_last, Cond, Op, Funct, Rn, Rd, Src2, Imm24,
    output in_ready, MemWE, Adr, WD, count, done, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes instruction field sets into 32-bit words and writes them to instruction memory.
// Optional macro ENCODER_CMD_CHECK_EN also rejects unsupported data-processing commands.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input logic            clk,
  input logic            reset,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  localparam logic [10:0] DepthW = 11'(DEPTH);

  state_e      state_q, state_d;
  logic [10:0] count_q, count_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wd_q, wd_d;
  logic        cmd_bad;
  logic        illegal;
  logic [31:0] enc_word;
  logic [10:0] count_inc;

`ifdef ENCODER_CMD_CHECK_EN
  assign cmd_bad = (bus.Op == 2'b00) &&
                   !((bus.Funct[4:1] == 4'b0100) || (bus.Funct[4:1] == 4'b0010) ||
                     (bus.Funct[4:1] == 4'b0000) || (bus.Funct[4:1] == 4'b1100));
`else
  assign cmd_bad = 1'b0;
`endif

  assign illegal   = (bus.Op == 2'b11) || cmd_bad;
  assign count_inc = count_q + 11'd1;

  always_comb begin
    if (bus.Op == 2'b10) begin
      enc_word = {bus.Cond, 2'b10, bus.Funct[5:4], bus.Imm24};
    end else begin
      enc_word = {bus.Cond, bus.Op, bus.Funct, bus.Rn, bus.Rd, bus.Src2};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Address and word are formed at capture; count cannot change before the WRITE cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    last_d  = last_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          if (illegal) begin
            err_d = 1'b1;
            if (bus.in_last) state_d = StDone;
          end else begin
            last_d  = bus.in_last;
            adr_d   = BASE_ADDR + {19'd0, count_q, 2'b00};
            wd_d    = enc_word;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        count_d = count_inc;
        state_d = (last_q || (count_inc == DepthW)) ? StDone : StLoad;
      end
      StDone: begin
        if (bus.start) begin
          state_d = StLoad;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    bus.in_ready = (state_q == StLoad);
    bus.MemWE    = (state_q == StWrite);
    bus.done     = (state_q == StDone);
    bus.count    = count_q;
    bus.err      = err_q;
    bus.Adr      = adr_q;
    bus.WD       = wd_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table of single-word sessions
// plus hand-written depth, illegal-word and reset-during-write sequences.
module tb_instr_encoder;

  localparam logic [31:0] Base  = 32'h0000_1000;
  localparam int unsigned Depth = 4;
  localparam int          NVec  = 7;

`ifdef ENCODER_CMD_CHECK_EN
  localparam bit CmdLegal = 1'b0;
`else
  localparam bit CmdLegal = 1'b1;
`endif

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm;
    bit          last;
    bit          legal;
    logic [31:0] wd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  instr_encoder_if bus ();

  instr_encoder #(
    .BASE_ADDR(Base),
    .DEPTH    (Depth)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          exp_count = 0;
  logic [31:0] last_adr = '0;
  logic [31:0] last_wd = '0;
  logic [63:0] sb_q[$];
  vec_t        tbl[NVec];

  function automatic vec_t mk(input logic [3:0] cond, input logic [1:0] op,
                              input logic [5:0] funct, input logic [3:0] rn,
                              input logic [3:0] rd, input logic [11:0] src2,
                              input logic [23:0] imm, input bit last, input bit legal,
                              input logic [31:0] wd);
    vec_t v;
    v.cond = cond; v.op = op; v.funct = funct; v.rn = rn; v.rd = rd;
    v.src2 = src2; v.imm = imm; v.last = last; v.legal = legal; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    exp_count = 0;
  endtask

  // Presents a field set with in_valid high (left high on return) and checks its outcome.
  task automatic send(input vec_t v, output bit acc);
    logic [63:0] e;
    bus.in_valid = 1'b1;
    bus.Cond = v.cond; bus.Op = v.op; bus.Funct = v.funct; bus.Rn = v.rn;
    bus.Rd = v.rd; bus.Src2 = v.src2; bus.Imm24 = v.imm; bus.in_last = v.last;
    acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.in_ready) begin
        acc = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      if (v.legal) begin
        sb_q.push_back({Base + 32'(exp_count) * 32'd4, v.wd});
        exp_count++;
        chk("write_latency", 32'(bus.MemWE), 32'd1);
        if (bus.MemWE && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("adr", bus.Adr, e[63:32]);
          chk("wd", bus.WD, e[31:0]);
          last_adr = e[63:32];
          last_wd  = e[31:0];
        end
      end else begin
        chk("illegal_no_write", 32'(bus.MemWE), 32'd0);
        chk("illegal_err", 32'(bus.err), 32'd1);
        chk("illegal_adr_hold", bus.Adr, last_adr);
        chk("illegal_wd_hold", bus.WD, last_wd);
      end
    end
  endtask

  initial begin
    bit   acc;
    vec_t v;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.Cond = '0; bus.Op = '0; bus.Funct = '0; bus.Rn = '0; bus.Rd = '0;
    bus.Src2 = '0; bus.Imm24 = '0;

    tbl[0] = mk(4'hE, 2'b00, 6'b101000, 4'h2, 4'h1, 12'h005, 24'h0, 1'b1, 1'b1, 32'hE282_1005);
    tbl[1] = mk(4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 12'h000, 24'h000003, 1'b1, 1'b1,
                32'hEA00_0003);
    tbl[2] = mk(4'hE, 2'b01, 6'b011000, 4'h0, 4'h3, 12'h008, 24'h0, 1'b1, 1'b1, 32'hE580_3008);
    tbl[3] = mk(4'h1, 2'b00, 6'b000100, 4'hF, 4'hA, 12'hABC, 24'h0, 1'b1, 1'b1, 32'h104F_AABC);
    tbl[4] = mk(4'h0, 2'b10, 6'b011111, 4'h5, 4'h6, 12'h777, 24'hABCDEF, 1'b1, 1'b1,
                32'h09AB_CDEF);
    tbl[5] = mk(4'hE, 2'b11, 6'b000000, 4'h1, 4'h1, 12'h111, 24'h0, 1'b1, 1'b0, 32'h0);
    tbl[6] = mk(4'hE, 2'b00, 6'b100110, 4'h3, 4'h4, 12'h123, 24'h0, 1'b1, CmdLegal,
                32'hE263_4123);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_memwe", 32'(bus.MemWE), 32'd0);
    chk("rst_adr", bus.Adr, 32'd0);
    chk("rst_wd", bus.WD, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Illegal field set offered while idle must be ignored.
    bus.in_valid = 1'b1; bus.Op = 2'b11; bus.in_last = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ignore_err", 32'(bus.err), 32'd0);
    chk("idle_ignore_memwe", 32'(bus.MemWE), 32'd0);
    bus.in_valid = 1'b0;

    for (int k = 0; k < NVec; k++) begin
      do_start();
      chk("start_err_clear", 32'(bus.err), 32'd0);
      chk("start_done_clear", 32'(bus.done), 32'd0);
      chk("start_ready", 32'(bus.in_ready), 32'd1);
      send(tbl[k], acc);
      bus.in_valid = 1'b0;
      chk("vec_accepted", 32'(acc), 32'd1);
      if (tbl[k].legal) begin
        @(negedge clk);
        chk("vec_done", 32'(bus.done), 32'd1);
        chk("vec_count", 32'(bus.count), 32'd1);
        chk("vec_memwe_low", 32'(bus.MemWE), 32'd0);
        chk("vec_wd_hold", bus.WD, tbl[k].wd);
        chk("vec_adr_hold", bus.Adr, Base);
      end else begin
        chk("ill_done", 32'(bus.done), 32'd1);
        chk("ill_count", 32'(bus.count), 32'd0);
      end
    end

    // Depth limit: six back-to-back words, only four accepted.
    do_start();
    for (int i = 0; i < 6; i++) begin
      v = mk(4'hE, 2'b01, 6'(i), 4'h1, 4'(i), 12'(i * 3), 24'h0, 1'b0, 1'b1,
             {4'hE, 2'b01, 6'(i), 4'h1, 4'(i), 12'(i * 3)});
      send(v, acc);
      chk("depth_accept", 32'(acc), (i < 4) ? 32'd1 : 32'd0);
    end
    bus.in_valid = 1'b0;
    chk("depth_done", 32'(bus.done), 32'd1);
    chk("depth_count", 32'(bus.count), 32'd4);
    chk("depth_last_adr", bus.Adr, Base + 32'hC);

    // Illegal word between two legal ones; start pulses in LOAD and WRITE are ignored.
    do_start();
    send(mk(4'hE, 2'b00, 6'b101000, 4'h2, 4'h1, 12'h005, 24'h0, 1'b0, 1'b1, 32'hE282_1005),
         acc);
    @(negedge clk);
    bus.start = 1'b1;
    send(mk(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 12'h000, 24'h0, 1'b0, 1'b0, 32'h0), acc);
    bus.start = 1'b0;
    chk("mid_ill_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_ill_count", 32'(bus.count), 32'd1);
    send(mk(4'hE, 2'b01, 6'b011000, 4'h0, 4'h3, 12'h008, 24'h0, 1'b1, 1'b1, 32'hE580_3008),
         acc);
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mid_done", 32'(bus.done), 32'd1);
    chk("mid_count", 32'(bus.count), 32'd2);
    chk("mid_err_sticky", 32'(bus.err), 32'd1);
    do_start();
    chk("restart_err_clear", 32'(bus.err), 32'd0);
    chk("restart_count_clear", 32'(bus.count), 32'd0);
    chk("restart_done_clear", 32'(bus.done), 32'd0);

    // Reset asserted in the middle of a WRITE cycle.
    send(mk(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0, 12'h0, 24'h000010, 1'b0, 1'b1, 32'h0800_0010),
         acc);
    @(negedge clk);
    send(mk(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0, 12'h0, 24'h000020, 1'b0, 1'b1, 32'h0800_0020),
         acc);
    bus.in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rstw_memwe", 32'(bus.MemWE), 32'd0);
    chk("rstw_count", 32'(bus.count), 32'd0);
    chk("rstw_ready", 32'(bus.in_ready), 32'd0);
    chk("rstw_adr", bus.Adr, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_count = 0; last_adr = '0; last_wd = '0;
    @(negedge clk);
    chk("rstw_idle", 32'(bus.in_ready), 32'd0);
    do_start();
    send(mk(4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 12'h0, 24'h000003, 1'b1, 1'b1, 32'hEA00_0003),
         acc);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 32'(bus.count), 32'd1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
